// File: rtl/systolic_drain_quant.sv
// Drain stage for the 32x32 systolic array: walks the 32 wrapped diagonals, requantizes each
// 32-lane accumulator vector to int8 and streams it to the output SRAM writer as one 256-bit write.
module systolic_drain_quant #(
  parameter int ARRAY_SIZE    = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int OUTCOME_WIDTH = 21,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                drain_start,
  input  logic [3:0]                          shift_amt,
  input  logic                                relu_en,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic [5:0]                          matrix_index,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ADDR_WIDTH-1:0]               out_addr,
  output logic [63:0]                         out_wdata0,
  output logic [63:0]                         out_wdata1,
  output logic [63:0]                         out_wdata2,
  output logic [63:0]                         out_wdata3,
  output logic                                busy,
  output logic                                done
);

  localparam int PACK_W = ARRAY_SIZE * DATA_WIDTH;
  localparam int IW     = OUTCOME_WIDTH + 1;
  localparam logic signed [IW-1:0] QMAX = IW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] QMIN = IW'(-(1 << (DATA_WIDTH - 1)));
  localparam logic [4:0] LAST = 5'(ARRAY_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_QUANT, S_WRITE, S_DONE} state_t;

  state_t                               state;
  logic [4:0]                           k;
  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0]  vec_q;
  logic [3:0]                           shift_q;
  logic                                 relu_q;
  logic [ADDR_WIDTH-1:0]                base_q;
  logic [PACK_W-1:0]                    quant_bus;

  // One extra bit of headroom keeps the rounding add from wrapping at the top of the lane range.
  function automatic logic [DATA_WIDTH-1:0] quantize(input logic [OUTCOME_WIDTH-1:0] x,
                                                     input logic [3:0] s,
                                                     input logic relu);
    logic signed [IW-1:0] wide;
    logic signed [IW-1:0] rnd;
    logic signed [IW-1:0] r;
    wide = $signed({x[OUTCOME_WIDTH-1], x});
    rnd  = (s == 4'd0) ? wide : wide + (IW'(1) <<< (s - 4'd1));
    r    = rnd >>> s;
    if (relu && r[IW-1]) r = '0;
    if (r > QMAX)      r = QMAX;
    else if (r < QMIN) r = QMIN;
    return r[DATA_WIDTH-1:0];
  endfunction

  // Lane 0 lands in the most significant byte of the packed 256-bit write.
  always_comb begin
    quant_bus = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      quant_bus[PACK_W-1-DATA_WIDTH*i -: DATA_WIDTH] =
        quantize(vec_q[i*OUTCOME_WIDTH +: OUTCOME_WIDTH], shift_q, relu_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k            <= '0;
      matrix_index <= '0;
      vec_q        <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      base_q       <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_wdata0   <= '0;
      out_wdata1   <= '0;
      out_wdata2   <= '0;
      out_wdata3   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (drain_start) begin
            shift_q      <= shift_amt;
            relu_q       <= relu_en;
            base_q       <= base_addr;
            k            <= '0;
            matrix_index <= '0;
            busy         <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          vec_q <= mul_outcome;
          state <= S_QUANT;
        end
        S_QUANT: begin
          out_wdata0 <= quant_bus[255:192];
          out_wdata1 <= quant_bus[191:128];
          out_wdata2 <= quant_bus[127:64];
          out_wdata3 <= quant_bus[63:0];
          out_addr   <= base_q + ADDR_WIDTH'(k);
          out_valid  <= 1'b1;
          state      <= S_WRITE;
        end
        // Word, address and valid stay frozen here until the writer takes them.
        S_WRITE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k == LAST) begin
              state <= S_DONE;
            end else begin
              k            <= k + 5'd1;
              matrix_index <= {1'b0, k + 5'd1};
              state        <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done         <= 1'b1;
          busy         <= 1'b0;
          matrix_index <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain_quant.sv
// Bench for systolic_drain_quant: a behavioural array model feeds mul_outcome by matrix_index and
// every accepted write is compared against an integer-arithmetic requantization model.
module tb_systolic_drain_quant;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         drain_start = 1'b0;
  logic [3:0]   shift_amt = '0;
  logic         relu_en = 1'b0;
  logic [9:0]   base_addr = '0;
  logic [N*21-1:0] mul_outcome;
  logic [5:0]   matrix_index;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [9:0]   out_addr;
  logic [63:0]  out_wdata0, out_wdata1, out_wdata2, out_wdata3;
  logic         busy, done;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  logic [20:0]  mat [N][N];
  logic [9:0]   got_addr[$];
  logic [255:0] got_data[$];
  logic [9:0]   stall_addr[$];
  logic [255:0] stall_data[$];
  logic [5:0]   stall_idx[$];
  logic [274:0] abort_snap;

  systolic_drain_quant dut (
    .clk(clk), .rst_n(rst_n), .drain_start(drain_start), .shift_amt(shift_amt),
    .relu_en(relu_en), .base_addr(base_addr), .mul_outcome(mul_outcome),
    .matrix_index(matrix_index), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_wdata0(out_wdata0), .out_wdata1(out_wdata1),
    .out_wdata2(out_wdata2), .out_wdata3(out_wdata3), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Array model: the output vector is a pure function of the index the drain presents.
  always_comb begin
    mul_outcome = '0;
    for (int i = 0; i < N; i++) mul_outcome[i*21 +: 21] = mat[matrix_index[4:0]][i];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back({out_wdata0, out_wdata1, out_wdata2, out_wdata3});
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [7:0] model_q(input logic [20:0] x, input int s, input bit relu);
    int v, d;
    v = int'($signed(x));
    if (s > 0) begin
      d = 1 << s;
      v = v + d / 2;
      v = (v >= 0) ? v / d : -((-v + d - 1) / d);
    end
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  function automatic logic [255:0] model_word(input int idx, input int s, input bit relu);
    logic [255:0] w;
    w = '0;
    for (int l = 0; l < N; l++) w[255-8*l -: 8] = model_q(mat[idx][l], s, relu);
    return w;
  endfunction

  task automatic fill_const(input logic [20:0] v);
    for (int a = 0; a < N; a++) for (int l = 0; l < N; l++) mat[a][l] = v;
  endtask

  task automatic fill_random();
    for (int a = 0; a < N; a++)
      for (int l = 0; l < N; l++)
        mat[a][l] = ($urandom_range(0, 1) == 1) ? 21'(int'($urandom_range(0, 8000)) - 4000)
                                                : 21'($urandom);
  endtask

  // mode 0: ready=1, 1: random ready, 2: 10-cycle stall on word 5, 3: spurious starts and config churn
  task automatic run_drain(input int s, input bit relu, input logic [9:0] base, input int mode,
                           input int abort_at, output int cycles);
    got_addr.delete(); got_data.delete();
    stall_addr.delete(); stall_data.delete(); stall_idx.delete();
    @(posedge clk); #1;
    shift_amt = 4'(s); relu_en = relu; base_addr = base; drain_start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    cycles = 0;
    while (cycles < 3000) begin
      if (done) break;
      if (abort_at >= 0 && got_addr.size() == abort_at) begin
        #2 rst_n = 1'b0;
        #1 abort_snap = {matrix_index, out_valid, out_addr, out_wdata0, out_wdata1,
                         out_wdata2, out_wdata3, busy, done};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (got_addr.size() == 5 && out_valid && stall_addr.size() < 10) begin
            out_ready = 1'b0;
            stall_addr.push_back(out_addr);
            stall_data.push_back({out_wdata0, out_wdata1, out_wdata2, out_wdata3});
            stall_idx.push_back(matrix_index);
          end else out_ready = 1'b1;
        end
        3: begin
          shift_amt = 4'($urandom); relu_en = 1'($urandom); base_addr = 10'($urandom);
          drain_start = (cycles == 20 || cycles == 50 || got_addr.size() == N);
        end
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cycles++;
    end
    drain_start = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #23;
    tests_run++;
    if ({matrix_index, out_valid, out_addr, out_wdata0, out_wdata1, out_wdata2, out_wdata3,
         busy, done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got valid=%b busy=%b done=%b idx=%0d addr=%0d, want all 0",
               out_valid, busy, done, matrix_index, out_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, d0;
    fill_const(21'd1000);
    d0 = done_cnt;
    run_drain(3, 1'b0, 10'd0, 0, -1, cyc);
    tests_run++;
    if (cyc !== 97) begin
      tests_failed++;
      $display("[TB] FAIL basic_done_cycle: got %0d, want 97", cyc);
    end
    tests_run++;
    if (got_addr.size() !== N || done_cnt !== d0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL basic_counts: got %0d writes %0d done, want 32 writes 1 done",
               got_addr.size(), done_cnt - d0);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got_addr[i] !== 10'(i) || got_data[i] !== {32{8'd125}}) begin
        tests_failed++;
        $display("[TB] FAIL basic_word%0d: got addr %0d data %h, want addr %0d all bytes 7d",
                 i, got_addr[i], got_data[i], i);
      end
    end
  endtask

  task automatic test_saturation();
    int cyc;
    logic [20:0] vals [4];
    logic [255:0] w0;
    vals[0] = 21'(5000); vals[1] = 21'(-5000); vals[2] = 21'(-3); vals[3] = 21'(3);
    for (int a = 0; a < N; a++) for (int l = 0; l < N; l++) mat[a][l] = vals[l % 4];
    for (int r = 0; r < 2; r++) begin
      run_drain(4, r[0], 10'd100, 0, -1, cyc);
      w0 = got_data[0];
      tests_run++;
      if (w0 !== ((r == 0) ? {4{64'h7F80_0000_7F80_0000}} : {4{64'h7F00_0000_7F00_0000}})) begin
        tests_failed++;
        $display("[TB] FAIL saturation relu=%0d: got %h", r, w0);
      end
      for (int i = 0; i < N; i++) begin
        tests_run++;
        if (got_addr[i] !== 10'(100 + i) || got_data[i] !== model_word(i, 4, r[0])) begin
          tests_failed++;
          $display("[TB] FAIL sat_word%0d relu=%0d: got addr %0d data %h, want addr %0d data %h",
                   i, r, got_addr[i], got_data[i], 100 + i, model_word(i, 4, r[0]));
        end
      end
    end
  endtask

  task automatic test_rounding();
    int cyc;
    logic [255:0] w;
    fill_random();
    for (int a = 0; a < N; a++) begin
      mat[a][0] = 21'(12); mat[a][1] = 21'(-12); mat[a][2] = 21'(-13);
    end
    run_drain(3, 1'b0, 10'd0, 0, -1, cyc);
    w = got_data[7];
    tests_run++;
    if (w[255 -: 8] !== 8'd2 || w[247 -: 8] !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL round_tie: got %h %h, want 02 ff", w[255 -: 8], w[247 -: 8]);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got_data[i] !== model_word(i, 3, 1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL round_word%0d: got %h, want %h", i, got_data[i], model_word(i, 3, 1'b0));
      end
    end
    run_drain(0, 1'b0, 10'd0, 0, -1, cyc);
    w = got_data[3];
    tests_run++;
    if (w[239 -: 8] !== 8'hF3 || got_data[20] !== model_word(20, 0, 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL round_shift0: got %h, want f3", w[239 -: 8]);
    end
  endtask

  task automatic test_backpressure();
    int cyc, d0, s;
    bit relu;
    logic [9:0] base;
    fill_random();
    s = $urandom_range(0, 15); relu = 1'($urandom); base = 10'($urandom);
    d0 = done_cnt;
    run_drain(s, relu, base, 2, -1, cyc);
    tests_run++;
    if (stall_addr.size() !== 10) begin
      tests_failed++;
      $display("[TB] FAIL stall_length: got %0d held cycles, want 10", stall_addr.size());
    end
    for (int i = 0; i < stall_addr.size(); i++) begin
      tests_run++;
      if (stall_addr[i] !== base + 10'd5 || stall_data[i] !== model_word(5, s, relu) ||
          stall_idx[i] !== 6'd5) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold%0d: got addr %0d idx %0d, want addr %0d idx 5",
                 i, stall_addr[i], stall_idx[i], base + 10'd5);
      end
    end
    tests_run++;
    if (got_addr.size() !== N || done_cnt !== d0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL stall_counts: got %0d writes %0d done, want 32 1", got_addr.size(), done_cnt - d0);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got_addr[i] !== base + 10'(i) || got_data[i] !== model_word(i, s, relu)) begin
        tests_failed++;
        $display("[TB] FAIL stall_word%0d: got addr %0d data %h, want addr %0d data %h",
                 i, got_addr[i], got_data[i], base + 10'(i), model_word(i, s, relu));
      end
    end
  endtask

  task automatic test_addr_wrap();
    int cyc, d0;
    fill_random();
    d0 = done_cnt;
    run_drain(5, 1'b1, 10'd1020, 3, -1, cyc);
    tests_run++;
    if (got_addr[3] !== 10'd1023 || got_addr[4] !== 10'd0 || got_addr[31] !== 10'd27) begin
      tests_failed++;
      $display("[TB] FAIL addr_wrap: got %0d %0d %0d, want 1023 0 27", got_addr[3], got_addr[4], got_addr[31]);
    end
    tests_run++;
    if (got_addr.size() !== N || done_cnt !== d0 + 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_counts: got %0d writes %0d done busy=%b, want 32 1 0",
               got_addr.size(), done_cnt - d0, busy);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got_addr[i] !== 10'd1020 + 10'(i) || got_data[i] !== model_word(i, 5, 1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL wrap_word%0d: got addr %0d data %h, want data %h",
                 i, got_addr[i], got_data[i], model_word(i, 5, 1'b1));
      end
    end
  endtask

  task automatic test_reset_abort();
    int cyc, d0;
    fill_random();
    d0 = done_cnt;
    run_drain(2, 1'b0, 10'd300, 0, 10, cyc);
    tests_run++;
    if (abort_snap !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_outputs: got %h, want 0", abort_snap);
    end
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (done_cnt !== d0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_quiet: got %0d done busy=%b valid=%b, want 0 0 0", done_cnt - d0, busy, out_valid);
    end
    run_drain(2, 1'b0, 10'd300, 1, -1, cyc);
    tests_run++;
    if (got_addr.size() !== N || done_cnt !== d0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL abort_redrain: got %0d writes %0d done, want 32 1", got_addr.size(), done_cnt - d0);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got_addr[i] !== 10'd300 + 10'(i) || got_data[i] !== model_word(i, 2, 1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL redrain_word%0d: got addr %0d data %h, want addr %0d data %h",
                 i, got_addr[i], got_data[i], 300 + i, model_word(i, 2, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    int cyc, d0, s;
    bit relu;
    logic [9:0] base;
    for (int n = 0; n < 3; n++) begin
      fill_random();
      s = $urandom_range(0, 15); relu = 1'($urandom); base = 10'($urandom);
      d0 = done_cnt;
      run_drain(s, relu, base, 1, -1, cyc);
      tests_run++;
      if (got_addr.size() !== N || done_cnt !== d0 + 1) begin
        tests_failed++;
        $display("[TB] FAIL random%0d_counts: got %0d writes %0d done, want 32 1", n, got_addr.size(), done_cnt - d0);
      end
      for (int i = 0; i < N; i++) begin
        tests_run++;
        if (got_addr[i] !== base + 10'(i) || got_data[i] !== model_word(i, s, relu)) begin
          tests_failed++;
          $display("[TB] FAIL random%0d_word%0d: got addr %0d data %h, want addr %0d data %h",
                   n, i, got_addr[i], got_data[i], base + 10'(i), model_word(i, s, relu));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_addr_wrap();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
